// File: rtl/limber_gnrl_edge_pkg.sv
// rtl/limber_gnrl_edge_pkg.sv - shared types and helpers for the generic edge detector
// Purpose: 2-bit per-channel edge mode encoding and the event-selection helper.
// Ports: none (package).
// Config macro: LIMBER_GNRL_EDGE_DEBOUNCE_EN (used by importing modules, not here).
package limber_gnrl_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic edge_event(input edge_mode_t mode, input logic rise, input logic fall);
    logic ev;
    ev = 1'b0;
    case (mode)
      EDGE_OFF:  ev = 1'b0;
      EDGE_RISE: ev = rise;
      EDGE_FALL: ev = fall;
      EDGE_BOTH: ev = rise | fall;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/limber_gnrl_edge_det_if.sv
// rtl/limber_gnrl_edge_det_if.sv - signal bundle for the generic edge detector
// Purpose: groups the monitored levels, modes, clears and event outputs.
// Ports (signals):
//   i_a[N], i_mode[2N], i_clr[N]   driven by master, consumed by the detector
//   o_pulse[N], o_flag[N], o_cnt[N*CNT_W], o_any   driven by the detector
// Modports: master (stimulus / consumer side), slave (detector side).
// Config macro: LIMBER_GNRL_EDGE_DEBOUNCE_EN (no effect on this bundle).
interface limber_gnrl_edge_det_if
  import limber_gnrl_edge_pkg::*;
#(
  parameter int N     = 1,
  parameter int CNT_W = 8
);
  logic [N-1:0]       i_a;
  logic [2*N-1:0]     i_mode;
  logic [N-1:0]       i_clr;
  logic [N-1:0]       o_pulse;
  logic [N-1:0]       o_flag;
  logic [N*CNT_W-1:0] o_cnt;
  logic               o_any;

  modport master (
    output i_a, i_mode, i_clr,
    input  o_pulse, o_flag, o_cnt, o_any
  );

  modport slave (
    input  i_a, i_mode, i_clr,
    output o_pulse, o_flag, o_cnt, o_any
  );
endinterface

// File: rtl/limber_gnrl_edge_chan.sv
// rtl/limber_gnrl_edge_chan.sv - one edge-detector channel
// Purpose: synchroniser, optional debounce filter, edge compare, sticky flag, saturating counter.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_a            monitored level (may be asynchronous)
//   i_mode         edge selection (off / rise / fall / both)
//   i_clr          write-1-clear of flag and counter
//   o_ev           combinational event (feeds the top-level any-OR)
//   o_pulse        registered one-cycle event pulse
//   o_flag         sticky event flag
//   o_cnt          saturating event count
// Config macro: LIMBER_GNRL_EDGE_DEBOUNCE_EN adds the debounce filter and DEBOUNCE_CYC.
module limber_gnrl_edge_chan
  import limber_gnrl_edge_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter bit RST_LVL      = 1'b0
`ifdef LIMBER_GNRL_EDGE_DEBOUNCE_EN
  ,parameter int DEBOUNCE_CYC = 4
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a,
  input  edge_mode_t       i_mode,
  input  logic             i_clr,
  output logic             o_ev,
  output logic             o_pulse,
  output logic             o_flag,
  output logic [CNT_W-1:0] o_cnt
);

  logic s;
  logic f;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = i_a;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d[0] = i_a;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= {SYNC_STAGES{RST_LVL}};
        else       sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

`ifdef LIMBER_GNRL_EDGE_DEBOUNCE_EN
  localparam int DBC_W = $clog2(DEBOUNCE_CYC + 1);

  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic             f_q, f_d;

  // The counter only runs while s disagrees with the accepted level; any
  // return to agreement before the threshold discards the candidate change.
  always_comb begin
    f_d   = f_q;
    dbc_d = '0;
    if (s != f_q) begin
      if (dbc_q == DBC_W'(DEBOUNCE_CYC - 1)) f_d = s;
      else                                   dbc_d = dbc_q + DBC_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dbc_q <= '0;
      f_q   <= RST_LVL;
    end else begin
      dbc_q <= dbc_d;
      f_q   <= f_d;
    end
  end

  assign f = f_q;
`else
  assign f = s;
`endif

  logic             p_q, p_d;
  logic             pulse_q, pulse_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ev;

  // History p tracks f in every mode, so enabling a channel later compares
  // against the current level and never fires on a stale one.
  always_comb begin
    ev      = edge_event(i_mode, f & ~p_q, ~f & p_q);
    p_d     = f;
    pulse_d = ev;
    flag_d  = ev | (flag_q & ~i_clr);
    cnt_d   = cnt_q;
    if (i_clr)                  cnt_d = ev ? CNT_W'(1) : '0;
    else if (ev && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_q     <= RST_LVL;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      p_q     <= p_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ev    = ev;
  assign o_pulse = pulse_q;
  assign o_flag  = flag_q;
  assign o_cnt   = cnt_q;

endmodule

// File: rtl/limber_gnrl_edge_det.sv
// rtl/limber_gnrl_edge_det.sv - N-channel mode-selectable edge detector
// Purpose: instantiates N independent channels and registers the any-event OR.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   bus (slave)    i_a / i_mode / i_clr in; o_pulse / o_flag / o_cnt / o_any out
// Config macro: LIMBER_GNRL_EDGE_DEBOUNCE_EN adds per-channel debounce (DEBOUNCE_CYC).
module limber_gnrl_edge_det
  import limber_gnrl_edge_pkg::*;
#(
  parameter int N            = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter bit RST_LVL      = 1'b0
`ifdef LIMBER_GNRL_EDGE_DEBOUNCE_EN
  ,parameter int DEBOUNCE_CYC = 4
`endif
) (
  input logic                 i_clk,
  input logic                 i_rst,
  limber_gnrl_edge_det_if.slave bus
);

  logic [N-1:0] ev;
  logic         any_q, any_d;

  for (genvar k = 0; k < N; k++) begin : g_chan
    limber_gnrl_edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RST_LVL     (RST_LVL)
`ifdef LIMBER_GNRL_EDGE_DEBOUNCE_EN
      ,.DEBOUNCE_CYC(DEBOUNCE_CYC)
`endif
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_a     (bus.i_a[k]),
      .i_mode  (edge_mode_t'(bus.i_mode[2*k +: 2])),
      .i_clr   (bus.i_clr[k]),
      .o_ev    (ev[k]),
      .o_pulse (bus.o_pulse[k]),
      .o_flag  (bus.o_flag[k]),
      .o_cnt   (bus.o_cnt[k*CNT_W +: CNT_W])
    );
  end

  // Built from the raw events so o_any lands in the same cycle as o_pulse.
  always_comb any_d = |ev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) any_q <= 1'b0;
    else       any_q <= any_d;
  end

  assign bus.o_any = any_q;

endmodule

// File: tb/tb_limber_gnrl_edge_det.sv
// tb/tb_limber_gnrl_edge_det.sv - self-checking bench for limber_gnrl_edge_det
// Purpose: vector table, directed corner sequences and a randomized run against a reference model.
// Config macro: LIMBER_GNRL_EDGE_DEBOUNCE_EN selects the debounce sequences instead.
module tb_limber_gnrl_edge_det;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int CW   = 2;
  localparam bit RL   = 1'b0;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic i_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  limber_gnrl_edge_det_if #(.N(N), .CNT_W(CW)) bus ();

`ifdef LIMBER_GNRL_EDGE_DEBOUNCE_EN
  limber_gnrl_edge_det #(.N(N), .SYNC_STAGES(S), .CNT_W(CW), .RST_LVL(RL), .DEBOUNCE_CYC(4))
    dut (.i_clk(clk), .i_rst(i_rst), .bus(bus));
`else
  limber_gnrl_edge_det #(.N(N), .SYNC_STAGES(S), .CNT_W(CW), .RST_LVL(RL))
    dut (.i_clk(clk), .i_rst(i_rst), .bus(bus));
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: level seen by the edge compare at edge n is the input
  // sampled S edges earlier; history holds the last S+1 sampled values.
  logic [N-1:0] hq[$];
  logic [N-1:0] m_pulse, m_flag;
  logic         m_any;
  int           m_cnt[N];

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i <= S; i++) hq.push_back({N{RL}});
    m_pulse = '0;
    m_flag  = '0;
    m_any   = 1'b0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  function automatic logic [N*CW-1:0] m_cnt_vec();
    logic [N*CW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'(m_cnt[k]);
    return v;
  endfunction

  task automatic tick();
    logic [N-1:0]   a_s, clr_s, prev, cur, ev;
    logic [2*N-1:0] mode_s;
    int             m;
    bit             up, dn;
    a_s    = bus.i_a;
    clr_s  = bus.i_clr;
    mode_s = bus.i_mode;
    @(posedge clk);
    #1;
    hq.push_back(a_s);
    prev = hq[0];
    cur  = hq[1];
    void'(hq.pop_front());
    for (int k = 0; k < N; k++) begin
      m     = int'(mode_s[2*k +: 2]);
      up    = (cur[k] == 1'b1) && (prev[k] == 1'b0);
      dn    = (cur[k] == 1'b0) && (prev[k] == 1'b1);
      ev[k] = (m == 1 && up) || (m == 2 && dn) || (m == 3 && (up || dn));
      if (ev[k])          m_flag[k] = 1'b1;
      else if (clr_s[k])  m_flag[k] = 1'b0;
      if (clr_s[k])       m_cnt[k] = ev[k] ? 1 : 0;
      else if (ev[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
    end
    m_pulse = ev;
    m_any   = |ev;
  endtask

  task automatic tick_chk(input string tag);
    tick();
    chk({tag, "_pulse"}, 64'(bus.o_pulse), 64'(m_pulse));
    chk({tag, "_flag"},  64'(bus.o_flag),  64'(m_flag));
    chk({tag, "_cnt"},   64'(bus.o_cnt),   64'(m_cnt_vec()));
    chk({tag, "_any"},   64'(bus.o_any),   64'(m_any));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]    a;
    logic [N-1:0]    clr;
    logic [N-1:0]    pulse;
    logic [N-1:0]    flag;
    logic [N*CW-1:0] cnt;
    logic            any;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [N-1:0] a, input logic [N-1:0] clr,
                              input logic [N-1:0] pulse, input logic [N-1:0] flag,
                              input logic [N*CW-1:0] cnt, input logic any);
    vec_t v;
    v.a = a; v.clr = clr; v.pulse = pulse; v.flag = flag; v.cnt = cnt; v.any = any;
    tbl.push_back(v);
  endfunction

  initial begin
    int first, npulse, n2;

    i_rst      = 1'b1;
    bus.i_a    = '0;
    bus.i_mode = 8'h55;
    bus.i_clr  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;

    chk("reset_pulse", 64'(bus.o_pulse), 64'h0);
    chk("reset_flag",  64'(bus.o_flag),  64'h0);
    chk("reset_cnt",   64'(bus.o_cnt),   64'h0);
    chk("reset_any",   64'(bus.o_any),   64'h0);

`ifndef LIMBER_GNRL_EDGE_DEBOUNCE_EN
    // ch0 rise mode: first edge, then saturation at 3, then clear behaviour.
    add(4'h1, 4'h0, 4'h0, 4'h0, 8'h0, 1'b0);
    add(4'h1, 4'h0, 4'h0, 4'h0, 8'h0, 1'b0);
    add(4'h1, 4'h0, 4'h1, 4'h1, 8'h1, 1'b1);
    add(4'h1, 4'h0, 4'h0, 4'h1, 8'h1, 1'b0);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h1, 1'b0);
    add(4'h1, 4'h0, 4'h0, 4'h1, 8'h1, 1'b0);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h1, 1'b0);
    add(4'h1, 4'h0, 4'h1, 4'h1, 8'h2, 1'b1);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h2, 1'b0);
    add(4'h1, 4'h0, 4'h1, 4'h1, 8'h3, 1'b1);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h3, 1'b0);
    add(4'h1, 4'h0, 4'h1, 4'h1, 8'h3, 1'b1);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h3, 1'b0);
    add(4'h0, 4'h0, 4'h1, 4'h1, 8'h3, 1'b1);
    add(4'h0, 4'h0, 4'h0, 4'h1, 8'h3, 1'b0);
    add(4'h0, 4'h1, 4'h0, 4'h0, 8'h0, 1'b0);
    add(4'h1, 4'h0, 4'h0, 4'h0, 8'h0, 1'b0);
    add(4'h1, 4'h0, 4'h0, 4'h0, 8'h0, 1'b0);
    add(4'h1, 4'h1, 4'h1, 4'h1, 8'h1, 1'b1);
    add(4'h1, 4'h0, 4'h0, 4'h1, 8'h1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.i_a   = tbl[i].a;
      bus.i_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_pulse", i), 64'(bus.o_pulse), 64'(tbl[i].pulse));
      chk($sformatf("tbl%0d_flag", i),  64'(bus.o_flag),  64'(tbl[i].flag));
      chk($sformatf("tbl%0d_cnt", i),   64'(bus.o_cnt),   64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_any", i),   64'(bus.o_any),   64'(tbl[i].any));
    end
    bus.i_clr = '0;

    // ch0 off, ch1 fall, ch2 both, ch3 off.
    bus.i_mode = 8'h38;
    bus.i_a    = 4'b0010;
    bus.i_clr  = 4'hF;
    n2 = 0;
    for (int t = 1; t <= 22; t++) begin
      if (t == 7)  bus.i_a = 4'b1100;
      if (t == 12) bus.i_a = 4'b0000;
      if (t == 18) bus.i_a = 4'b1000;
      tick_chk("modes");
      bus.i_clr = '0;
      if (bus.o_pulse[2]) n2++;
    end
    chk("modes_ch2_pulses", 64'(n2), 64'd2);
    chk("modes_cnt", 64'(bus.o_cnt), 64'h24);
    chk("modes_flag", 64'(bus.o_flag), 64'h6);

    // Asynchronous reset mid-count, then a level held high through release.
    @(posedge clk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("rst_async_flag",  64'(bus.o_flag),  64'h0);
    chk("rst_async_cnt",   64'(bus.o_cnt),   64'h0);
    chk("rst_async_pulse", 64'(bus.o_pulse), 64'h0);
    chk("rst_async_any",   64'(bus.o_any),   64'h0);
    bus.i_a    = 4'b0001;
    bus.i_mode = 8'h55;
    bus.i_clr  = '0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    first  = -1;
    npulse = 0;
    for (int t = 1; t <= 8; t++) begin
      tick_chk("rst_rel");
      if (bus.o_pulse[0]) begin
        npulse++;
        if (first < 0) first = t;
      end
    end
    chk("rst_rel_npulse", 64'(npulse), 64'd1);
    chk("rst_rel_latency", 64'(first), 64'd3);

    // Randomized run: sparse level flips, occasional mode changes and clears.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 1) == 0) bus.i_a = bus.i_a ^ N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) bus.i_mode = (2*N)'($urandom);
      bus.i_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      tick_chk("rand");
    end
`else
    // 3-cycle glitch must be ignored.
    npulse = 0;
    repeat (3) step();
    bus.i_a = 4'b0001;
    repeat (3) begin
      step();
      if (bus.o_pulse[0]) npulse++;
    end
    bus.i_a = 4'b0000;
    repeat (15) begin
      step();
      if (bus.o_pulse[0]) npulse++;
    end
    chk("dbc_glitch_npulse", 64'(npulse), 64'd0);
    chk("dbc_glitch_flag", 64'(bus.o_flag), 64'h0);

    // Stable level accepted after the debounce window.
    bus.i_a = 4'b0001;
    first  = -1;
    npulse = 0;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (bus.o_pulse[0]) begin
        npulse++;
        if (first < 0) first = t;
      end
    end
    chk("dbc_stable_npulse", 64'(npulse), 64'd1);
    chk("dbc_stable_latency", 64'(first), 64'd7);
    chk("dbc_stable_cnt", 64'(bus.o_cnt), 64'h1);
    n2 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
